// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and a parity helper.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // Parity bit value that makes the frame correct for the selected sense (odd=0 -> even).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversampling tick generator: one-clk baud_tick pulse at OVERSAMPLE * BAUD_RATE.
module baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic baud_tick
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign baud_tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam logic [3:0] MID_CNT  = 4'(MID_TICK);
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

  logic       baud_tick;
  logic       sync1_q, sync2_q;
  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       pending_q, pending_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic       stop_sample;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       parity_err_q, parity_err_d;
`endif

  baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(baud_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= IDLE;
      tick_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      pending_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      sync1_q       <= rx;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      pending_q     <= pending_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          // Re-check mid start bit so short low glitches are rejected.
          if (tick_q == MID_CNT) begin
            if (!sync2_q) begin
              state_d   = DATA;
              tick_d    = '0;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == LAST_CNT) begin
            shift_d[bit_idx_q] = sync2_q;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == LAST_CNT) begin
            par_d   = sync2_q;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == LAST_CNT) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy       = (state_q != IDLE);
    stop_sample   = baud_tick && (state_q == STOP) && (tick_q == LAST_CNT);
    pending_d     = stop_sample && sync2_q;
    frame_err_d   = stop_sample && !sync2_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = 1'b0;
`endif
    // A delivery in the same cycle as a handshake replaces the consumed byte cleanly.
    if (pending_q) begin
      rx_data_d     = shift_q;
      rx_valid_d    = 1'b1;
      overrun_err_d = rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err_d  = (par_q != parity_bit(shift_q, PARITY_ODD[0]));
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
  assign parity_err        = 1'b0;
`endif

endmodule
